// File: rtl/nand_stimulus_sequencer_pkg.sv
// Shared types and constants for the gate-lab stimulus sequencer.
// Truth tables are indexed by vector value, A as the MSB.
package nand_stimulus_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    DONE
  } state_e;

  function automatic int n_vec(input int n_in);
    return 1 << n_in;
  endfunction

  localparam logic [7:0] NAND3_TT = 8'h7F;
  localparam logic [7:0] AND3_TT  = 8'h80;
  localparam logic [7:0] OR3_TT   = 8'hFE;

endpackage

// File: rtl/nand_stimulus_sequencer_if.sv
// Sweep handshake, stimulus vector and result bus.
// master is the sequencer, slave is the host/gate side.
interface nand_stimulus_sequencer_if #(
  parameter int N_IN = 3
);
  localparam int NV = 1 << N_IN;

  logic            start;
  logic            D_IN;
  logic [N_IN-1:0] VEC;
  logic            busy;
  logic            done;
  logic [NV-1:0]   RESULT;
  logic [NV-1:0]   MISMATCH;
  logic            PASS;

  modport master (
    input  start, D_IN,
    output VEC, busy, done,
    output RESULT, MISMATCH, PASS
  );

  modport slave (
    output start, D_IN,
    input  VEC, busy, done,
    input  RESULT, MISMATCH, PASS
  );
endinterface

// File: rtl/nand_stimulus_sequencer_hold_timer.sv
// Modulo-HOLD_CYCLES counter; tc marks the last
// cycle of each hold window while enabled.
module nand_stimulus_sequencer_hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);
  localparam int CW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // terminal count and next count, wrapping at LAST
  always_comb begin
    cnt_d = cnt_q;
    tc    = en && (cnt_q == LAST);
    if (clr)     cnt_d = '0;
    else if (tc) cnt_d = '0;
    else if (en) cnt_d = cnt_q + CW'(1);
  end

  // counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/nand_stimulus_sequencer.sv
// Exhaustive stimulus sweep for a small combinational gate:
// applies every vector, samples the output, grades it.
module nand_stimulus_sequencer
  import nand_stimulus_sequencer_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int HOLD_CYCLES = 4,
  parameter logic [n_vec(N_IN)-1:0] EXPECTED = NAND3_TT
) (
  input logic clk,
  input logic rst,
  nand_stimulus_sequencer_if.master bus
);
  localparam int NV = n_vec(N_IN);
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NV - 1);

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [NV-1:0]   result_q, result_d;
  logic [NV-1:0]   mismatch_q, mismatch_d;
  logic            pass_q, pass_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            tmr_en, tmr_clr, tmr_tc;

  nand_stimulus_sequencer_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk(clk),
    .rst(rst),
    .en (tmr_en),
    .clr(tmr_clr),
    .tc (tmr_tc)
  );

  // sweep FSM, result map and grading
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    result_d   = result_q;
    mismatch_d = mismatch_q;
    pass_d     = pass_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tmr_en     = 1'b0;
    tmr_clr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = APPLY;
          vec_d      = '0;
          result_d   = '0;
          mismatch_d = '0;
          pass_d     = 1'b0;
          busy_d     = 1'b1;
          tmr_clr    = 1'b1;
        end
      end
      APPLY: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          result_d[vec_q] = bus.D_IN;
          if (vec_q == LAST_VEC) state_d = DONE;
          else vec_d = vec_q + N_IN'(1);
        end
      end
      DONE: begin
        done_d     = 1'b1;
        busy_d     = 1'b0;
        mismatch_d = result_q ^ EXPECTED;
        pass_d     = (result_q == EXPECTED);
        vec_d      = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      result_q   <= '0;
      mismatch_q <= '0;
      pass_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      result_q   <= result_d;
      mismatch_q <= mismatch_d;
      pass_q     <= pass_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.VEC      = vec_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.RESULT   = result_q;
  assign bus.MISMATCH = mismatch_q;
  assign bus.PASS     = pass_q;
endmodule
